// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - DB15 serial joystick device model: parallel snapshot, serial shift-out on host JOY_CLK
// Optional build macro: JOY_DB15_TX_GLITCH_EN adds a 3-sample majority filter on the synchronized JOY_CLK.
module joy_db15_tx #(
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] joystick1,
    input  logic [11:0] joystick2,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] ck_sync_q;
    logic [SYNC_STAGES-1:0] ld_sync_q;
    logic                   ck_edge_src;
    logic                   ck_hist_q;
    logic                   ld_hist_q;
    logic                   ck_rise_q;
    logic                   ld_rise_q;

    state_t                 state_q;
    logic [23:0]            shreg_q;
    logic [4:0]             cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovr_q;

    // Bring the asynchronous host strobes into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            ck_sync_q <= '0;
            ld_sync_q <= '0;
        end else begin
            ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], JOY_CLK};
            ld_sync_q <= {ld_sync_q[SYNC_STAGES-2:0], JOY_LOAD};
        end
    end

`ifdef JOY_DB15_TX_GLITCH_EN
    logic ck_s1_q;
    logic ck_s2_q;
    logic ck_filt_q;

    // Majority of three consecutive samples; a lone high or low sample never wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ck_s1_q   <= 1'b0;
            ck_s2_q   <= 1'b0;
            ck_filt_q <= 1'b0;
        end else begin
            ck_s1_q   <= ck_sync_q[SYNC_STAGES-1];
            ck_s2_q   <= ck_s1_q;
            ck_filt_q <= (ck_sync_q[SYNC_STAGES-1] & ck_s1_q) |
                         (ck_sync_q[SYNC_STAGES-1] & ck_s2_q) |
                         (ck_s1_q & ck_s2_q);
        end
    end

    assign ck_edge_src = ck_filt_q;
`else
    assign ck_edge_src = ck_sync_q[SYNC_STAGES-1];
`endif

    // Rising-edge detection; pulses are registered so both paths stay cycle-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            ck_hist_q <= 1'b0;
            ld_hist_q <= 1'b0;
            ck_rise_q <= 1'b0;
            ld_rise_q <= 1'b0;
        end else begin
            ck_hist_q <= ck_edge_src;
            ld_hist_q <= ld_sync_q[SYNC_STAGES-1];
            ck_rise_q <= ck_edge_src & ~ck_hist_q;
            ld_rise_q <= ld_sync_q[SYNC_STAGES-1] & ~ld_hist_q;
        end
    end

    // Frame FSM: load wins over clock; shift register bit 0 is the bit on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld_rise_q) begin
                shreg_q <= ~{joystick2, joystick1};
                cnt_q   <= 5'd1;
                state_q <= ST_SHIFT;
                busy_q  <= 1'b1;
                if (state_q == ST_SHIFT) begin
                    ovr_q <= 1'b1;
                end
            end else if (ck_rise_q && !ld_hist_q && state_q == ST_SHIFT) begin
                if (cnt_q == LAST_BIT) begin
                    shreg_q <= '1;
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    shreg_q <= {1'b1, shreg_q[23:1]};
                    cnt_q   <= cnt_q + 5'd1;
                end
            end
        end
    end

    assign JOY_DATA   = shreg_q[0];
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb/tb_joy_db15_tx.sv - randomized scoreboard bench for joy_db15_tx against a frame-level model
module tb_joy_db15_tx;

    localparam int FB = 24;
`ifdef JOY_DB15_TX_GLITCH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] j1 = '0;
    logic [11:0] j2 = '0;
    logic        jclk = 1'b0;
    logic        jload = 1'b0;
    logic        jdata;
    logic        busy;
    logic        fdone;
    logic        ovr;

    always #5 clk = ~clk;

    joy_db15_tx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .joystick1  (j1),
        .joystick2  (j2),
        .JOY_CLK    (jclk),
        .JOY_LOAD   (jload),
        .JOY_DATA   (jdata),
        .busy       (busy),
        .frame_done (fdone),
        .overrun    (ovr)
    );

    typedef struct {
        logic data;
        logic busy;
        logic ovr;
        int   fd;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   fd_seen = 0;
    event probe;

    // Frame-level reference: a queue of the bits still to be presented.
    bit   mq[$];
    logic m_busy = 1'b0;
    logic m_ovr = 1'b0;
    logic m_data = 1'b1;
    int   fd_exp = 0;

    task automatic m_load(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] w;
        w = ~{b, a};
        m_ovr = m_ovr | m_busy;
        mq.delete();
        for (int i = 0; i < FB; i++) mq.push_back(w[i]);
        m_busy = 1'b1;
        m_data = mq[0];
    endtask

    task automatic m_clock();
        if (m_busy) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                m_busy = 1'b0;
                m_data = 1'b1;
                fd_exp++;
            end else begin
                m_data = mq[0];
            end
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_busy = 1'b0;
        m_ovr  = 1'b0;
        m_data = 1'b1;
    endtask

    task automatic push_exp();
        exp_q.push_back('{m_data, m_busy, m_ovr, fd_exp});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: each host action first samples the settled outputs of the previous one.
    initial begin
        forever begin
            @(probe);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                total++;
                if (jdata !== cur.data || busy !== cur.busy || ovr !== cur.ovr || fd_seen != cur.fd) begin
                    bad++;
                    $display("FAIL probe t=%0t: got data=%0b busy=%0b overrun=%0b frames=%0d, want data=%0b busy=%0b overrun=%0b frames=%0d",
                             $time, jdata, busy, ovr, fd_seen, cur.data, cur.busy, cur.ovr, cur.fd);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (fdone === 1'b1) begin
            fd_seen++;
            total++;
            if (jdata !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL frame_done_coincident t=%0t: got data=%0b busy=%0b, want data=1 busy=0",
                         $time, jdata, busy);
            end
        end
    end

    task automatic act_load(input logic [11:0] a, input logic [11:0] b);
        @(negedge clk);
        ->probe;
        j1 = a;
        j2 = b;
        jload = 1'b1;
        m_load(a, b);
        push_exp();
        idle(6);
        jload = 1'b0;
        idle(6);
    endtask

    task automatic act_clk(input bit meas);
        logic old;
        int   lat;
        @(negedge clk);
        ->probe;
        if ($urandom_range(0, 3) == 0) begin
            j1 = 12'($urandom);
            j2 = 12'($urandom);
        end
        old = jdata;
        jclk = 1'b1;
        if (meas) begin
            lat = -1;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                if (jdata !== old) begin
                    lat = k;
                    break;
                end
            end
            total++;
            if (lat != LAT) begin
                bad++;
                $display("FAIL clk_latency: got %0d edges, want %0d", lat, LAT);
            end
            idle(3);
        end else begin
            idle(6);
        end
        jclk = 1'b0;
        idle(6);
        m_clock();
        push_exp();
    endtask

    task automatic act_both(input logic [11:0] a, input logic [11:0] b);
        @(negedge clk);
        ->probe;
        j1 = a;
        j2 = b;
        jload = 1'b1;
        jclk = 1'b1;
        m_load(a, b);
        push_exp();
        idle(8);
        jload = 1'b0;
        idle(4);
        jclk = 1'b0;
        idle(6);
    endtask

    task automatic act_glitch();
        @(negedge clk);
        ->probe;
        jclk = 1'b1;
        @(negedge clk);
        jclk = 1'b0;
        idle(10);
`ifndef JOY_DB15_TX_GLITCH_EN
        m_clock();
`endif
        push_exp();
    endtask

    task automatic act_reset();
        @(negedge clk);
        ->probe;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        push_exp();
        idle(4);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        idle(3);
        reset = 1'b0;
        m_reset();
        push_exp();
        idle(4);

        // No load: clocks must leave the line idle.
        repeat (30) act_clk(1'b0);

        // Single-ended pattern, with latency measured on the first shift.
        act_load(12'h001, 12'h800);
        act_clk(1'b1);
        repeat (23) act_clk(1'b0);

        // Reload mid-frame raises overrun.
        act_load(12'($urandom), 12'($urandom));
        repeat (10) act_clk(1'b0);
        act_load(12'h0F0, 12'($urandom));
        repeat (4) act_clk(1'b0);
        act_reset();

        // Load and clock together while busy: load only.
        act_load(12'($urandom), 12'($urandom));
        repeat (5) act_clk(1'b0);
        act_both(12'h3C5, 12'($urandom));
        repeat (3) act_clk(1'b0);
        act_reset();

        // Reset halfway through a frame.
        act_load(12'($urandom), 12'($urandom));
        repeat (12) act_clk(1'b0);
        act_reset();
        repeat (5) act_clk(1'b0);

        // One-cycle clock glitch mid-frame.
        act_load(12'h555, 12'hAAA);
        repeat (3) act_clk(1'b0);
        act_glitch();
        repeat (4) act_clk(1'b0);

        act_reset();
        repeat (300) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) act_load(12'($urandom), 12'($urandom));
            else if (r < 18) act_reset();
            else if (r < 22) act_both(12'($urandom), 12'($urandom));
            else act_clk(1'b0);
        end

        @(negedge clk);
        ->probe;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
